// File: rtl/cell_vector_sweeper.sv
// Exhaustive vector sweeper for single-output library cells: drives every input code, samples zn
// after a settle window, checks it against TRUTH. Optional SWEEP_STOP_ON_FAIL_EN ends on first miss.
module cell_vector_sweeper #(
  parameter int                 N_IN   = 4,
  parameter int                 SETTLE = 2,
  parameter logic [2**N_IN-1:0] TRUTH  = 16'h8000
) (
  input  logic            CK,
  input  logic            RN,
  input  logic            start,
  output logic [N_IN-1:0] vec,
  input  logic            zn,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_cnt,
  output logic            fail_valid,
  output logic [N_IN-1:0] fail_vec
);

  localparam int HCW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_DONE} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [HCW-1:0]    r_hcnt;
  logic [N_IN-1:0]   r_vec;
  logic              r_busy;
  logic              r_done;
  logic [N_IN:0]     r_err_cnt;
  logic              r_fail_valid;
  logic [N_IN-1:0]   r_fail_vec;

  logic              w_start;
  logic              w_sample;
  logic              w_mismatch;
  logic              w_last;
  logic              w_end;
  logic [N_IN-1:0]   w_end_vec;

  assign w_start    = (r_state != S_HOLD) && start;
  assign w_sample   = (r_state == S_HOLD) && (r_hcnt == HCW'(SETTLE - 1));
  // Case inequality so an X/Z on the cell output is never mistaken for a match.
  assign w_mismatch = (zn !== TRUTH[r_vec]);
  assign w_last     = (r_vec == {N_IN{1'b1}});

`ifdef SWEEP_STOP_ON_FAIL_EN
  assign w_end     = w_sample && (w_last || w_mismatch);
  assign w_end_vec = w_mismatch ? r_vec : '0;
`else
  assign w_end     = w_sample && w_last;
  assign w_end_vec = '0;
`endif

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (start) w_next = S_HOLD;
      S_HOLD:         if (w_end) w_next = S_DONE;
      default:        w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      r_vec        <= '0;
      r_hcnt       <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err_cnt    <= '0;
      r_fail_valid <= 1'b0;
      r_fail_vec   <= '0;
    end else if (w_start) begin
      r_vec        <= '0;
      r_hcnt       <= '0;
      r_busy       <= 1'b1;
      r_done       <= 1'b0;
      r_err_cnt    <= '0;
      r_fail_valid <= 1'b0;
      r_fail_vec   <= '0;
    end else if (r_state == S_HOLD) begin
      if (!w_sample) begin
        r_hcnt <= r_hcnt + HCW'(1);
      end else begin
        r_hcnt <= '0;
        if (w_mismatch) begin
          r_err_cnt <= r_err_cnt + (N_IN+1)'(1);
          if (!r_fail_valid) begin
            r_fail_valid <= 1'b1;
            r_fail_vec   <= r_vec;
          end
        end
        if (w_end) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
          r_vec  <= w_end_vec;
        end else begin
          r_vec  <= r_vec + N_IN'(1);
        end
      end
    end
  end

  assign vec        = r_vec;
  assign busy       = r_busy;
  assign done       = r_done;
  assign pass       = r_done && (r_err_cnt == '0);
  assign err_cnt    = r_err_cnt;
  assign fail_valid = r_fail_valid;
  assign fail_vec   = r_fail_vec;

endmodule

// File: tb/tb_cell_vector_sweeper.sv
// Scoreboard bench for cell_vector_sweeper: a behavioural cell with selectable faults feeds zn,
// expected sweep results are queued at start and compared when done rises.
module tb_cell_vector_sweeper;

  typedef struct {
    int err;
    int fv;
    int fvec;
    int pass;
    int cyc;
    int vec;
  } exp_t;

  logic       CK;
  logic       RN;
  logic       start;
  logic       zn;
  logic [3:0] vec;
  logic       busy;
  logic       done;
  logic       pass;
  logic [4:0] err_cnt;
  logic       fail_valid;
  logic [3:0] fail_vec;

  logic       start1;
  logic       zn1;
  logic [3:0] vec1;
  logic       busy1;
  logic       done1;
  logic       pass1;
  logic [4:0] err_cnt1;
  logic       fail_valid1;
  logic [3:0] fail_vec1;

  int   cur_mode;
  int   errs;
  int   checks;
  exp_t sb[$];

  cell_vector_sweeper #(.N_IN(4), .SETTLE(2), .TRUTH(16'h8000)) u_dut (
    .CK(CK), .RN(RN), .start(start), .vec(vec), .zn(zn), .busy(busy), .done(done),
    .pass(pass), .err_cnt(err_cnt), .fail_valid(fail_valid), .fail_vec(fail_vec)
  );

  cell_vector_sweeper #(.N_IN(4), .SETTLE(1), .TRUTH(16'h8000)) u_dut_s1 (
    .CK(CK), .RN(RN), .start(start1), .vec(vec1), .zn(zn1), .busy(busy1), .done(done1),
    .pass(pass1), .err_cnt(err_cnt1), .fail_valid(fail_valid1), .fail_vec(fail_vec1)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  // Behavioural cell: 0 healthy AND4, 1 stuck-at-0, 2 stuck-at-1, 3 X on vector 5, 4 inverted on 3 and 9
  function automatic logic cell_zn(input logic [3:0] v, input int mode);
    logic z;
    case (mode)
      1:       z = 1'b0;
      2:       z = 1'b1;
      3:       z = (v == 4'd5) ? 1'bx : &v;
      4:       z = (v == 4'd3 || v == 4'd9) ? ~(&v) : &v;
      default: z = &v;
    endcase
    return z;
  endfunction

  assign zn  = cell_zn(vec, cur_mode);
  assign zn1 = &vec1;

  function automatic exp_t model(input int mode, input int settle);
    exp_t        e;
    logic [15:0] tt;
    logic [3:0]  v4;
    logic        z;
    tt = 16'h8000;
    e.err = 0; e.fv = 0; e.fvec = 0; e.vec = 0; e.cyc = 16 * settle;
    for (int v = 0; v < 16; v++) begin
      v4 = v[3:0];
      z  = cell_zn(v4, mode);
      if (z !== tt[v]) begin
        e.err++;
        if (e.fv == 0) begin
          e.fv   = 1;
          e.fvec = v;
        end
`ifdef SWEEP_STOP_ON_FAIL_EN
        e.cyc = (v + 1) * settle;
        e.vec = v;
        break;
`endif
      end
    end
    e.pass = (e.err == 0) ? 1 : 0;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic collect(input string tag);
    int   n;
    exp_t e;
    n = 0;
    while (n < 200 && !done) begin
      @(posedge CK);
      #1;
      n++;
    end
    chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_latency"},    32'(n),          32'(e.cyc));
      chk({tag, "_err_cnt"},    32'(err_cnt),    32'(e.err));
      chk({tag, "_fail_valid"}, 32'(fail_valid), 32'(e.fv));
      chk({tag, "_fail_vec"},   32'(fail_vec),   32'(e.fvec));
      chk({tag, "_pass"},       32'(pass),       32'(e.pass));
      chk({tag, "_vec"},        32'(vec),        32'(e.vec));
      chk({tag, "_busy"},       32'(busy),       32'd0);
    end
  endtask

  task automatic launch(input int mode, input bit hold);
    cur_mode = mode;
    sb.push_back(model(mode, 2));
    @(negedge CK);
    start = 1'b1;
    @(posedge CK);
    #1;
    if (!hold) start = 1'b0;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_done", 32'(done), 32'd0);
  endtask

  initial begin
    int n1;
    errs = 0; checks = 0; cur_mode = 0;
    start = 1'b0; start1 = 1'b0; RN = 1'b1;
    #2 RN = 1'b0;
    repeat (3) @(posedge CK);
    #1;
    chk("rst_vec",        32'(vec),        32'd0);
    chk("rst_busy",       32'(busy),       32'd0);
    chk("rst_done",       32'(done),       32'd0);
    chk("rst_pass",       32'(pass),       32'd0);
    chk("rst_err_cnt",    32'(err_cnt),    32'd0);
    chk("rst_fail_valid", 32'(fail_valid), 32'd0);
    chk("rst_fail_vec",   32'(fail_vec),   32'd0);
    @(negedge CK);
    RN = 1'b1;

    for (int m = 0; m < 5; m++) begin
      launch(m, 1'b0);
      collect($sformatf("mode%0d", m));
    end

    // Reset mid-sweep with a stuck-at-1 cell so there is state worth losing
    cur_mode = 2;
    @(negedge CK);
    start = 1'b1;
    @(posedge CK);
    #1 start = 1'b0;
    repeat (10) @(posedge CK);
    #1;
`ifdef SWEEP_STOP_ON_FAIL_EN
    chk("pre_rst_err", 32'(err_cnt), 32'd1);
`else
    chk("pre_rst_err", 32'(err_cnt), 32'd5);
`endif
    #2 RN = 1'b0;
    #1;
    chk("mid_rst_vec",        32'(vec),        32'd0);
    chk("mid_rst_busy",       32'(busy),       32'd0);
    chk("mid_rst_done",       32'(done),       32'd0);
    chk("mid_rst_err_cnt",    32'(err_cnt),    32'd0);
    chk("mid_rst_fail_valid", 32'(fail_valid), 32'd0);
    chk("mid_rst_fail_vec",   32'(fail_vec),   32'd0);
    @(negedge CK);
    RN = 1'b1;
    launch(0, 1'b0);
    collect("post_rst");

    // start held through the sweep: must finish, then restart once from DONE
    sb.push_back(model(0, 2));
    launch(0, 1'b1);
    collect("held");
    @(posedge CK);
    #1;
    chk("restart_done_low", 32'(done), 32'd0);
    chk("restart_busy",     32'(busy), 32'd1);
    chk("restart_vec",      32'(vec),  32'd0);
    start = 1'b0;
    collect("held_restart");

    // SETTLE=1 instance
    @(negedge CK);
    start1 = 1'b1;
    @(posedge CK);
    #1 start1 = 1'b0;
    n1 = 0;
    while (n1 < 100 && !done1) begin
      @(posedge CK);
      #1;
      n1++;
    end
    chk("s1_latency", 32'(n1),       32'd16);
    chk("s1_err_cnt", 32'(err_cnt1), 32'd0);
    chk("s1_pass",    32'(pass1),    32'd1);
    chk("s1_vec",     32'(vec1),     32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
